// File: rtl/mips_ctrl_fsm.sv
// Multicycle main controller for the 8-bit MIPS datapath.
// Moore FSM: fetch (4 byte cycles), decode, then per-opcode execute chain.
module mips_ctrl_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LB    = 6'b100000,
    parameter logic [5:0] OP_SB    = 6'b101000,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic [1:0] pcsource,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg
);

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13
    } state_t;

    // ADDIWR shares no encoding with the enum above to keep 14 and 15
    // distinct; 15 is the only truly unused code.
    localparam state_t ADDIWR = state_t'(4'd14);

    state_t state, next_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH1;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH1;
        case (state)
            FETCH1: next_state = FETCH2;
            FETCH2: next_state = FETCH3;
            FETCH3: next_state = FETCH4;
            FETCH4: next_state = DECODE;
            DECODE: begin
                if (op == OP_LB || op == OP_SB) next_state = MEMADR;
                else if (op == OP_RTYPE)        next_state = RTYPEEX;
                else if (op == OP_BEQ)          next_state = BEQEX;
                else if (op == OP_J)            next_state = JEX;
                else if (op == OP_ADDI)         next_state = ADDIEX;
                else                            next_state = FETCH1;
            end
            MEMADR: begin
                if (op == OP_LB)      next_state = LBRD;
                else if (op == OP_SB) next_state = SBWR;
                else                  next_state = FETCH1;
            end
            LBRD:    next_state = LBWR;
            RTYPEEX: next_state = RTYPEWR;
            ADDIEX:  next_state = ADDIWR;
            default: next_state = FETCH1;
        endcase
    end

    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 4'b0000;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        pcsource = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        case (state)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                irwrite = 4'b0001 << state[1:0];
            end
            DECODE: alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BEQEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                branch   = 1'b1;
                pcsource = 2'b01;
            end
            JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            ADDIWR: regwrite = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed and randomized-order bench for mips_ctrl_fsm.
// Outputs are packed into one vector and checked against hand-built values.
module tb_mips_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       memread, memwrite, iord, pcwrite, branch;
    logic       alusrca, regwrite, regdst, memtoreg;
    logic [3:0] irwrite;
    logic [1:0] pcsource, alusrcb, aluop;
    logic [18:0] outv;

    int checks = 0;
    int errors = 0;

    mips_ctrl_fsm dut (
        .clk(clk), .reset(reset), .op(op),
        .memread(memread), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
        .pcsource(pcsource), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg)
    );

    always #5 clk = ~clk;

    assign outv = {memread, memwrite, iord, irwrite, pcwrite, branch,
                   pcsource, alusrca, alusrcb, aluop,
                   regwrite, regdst, memtoreg};

    // field order: mr mw iord irw pcw br pcs asa asb aop rw rd m2r
    localparam logic [18:0] F1  = {3'b100, 4'b0001, 2'b10, 2'b00, 1'b0, 2'b01, 2'b00, 3'b000};
    localparam logic [18:0] F2  = {3'b100, 4'b0010, 2'b10, 2'b00, 1'b0, 2'b01, 2'b00, 3'b000};
    localparam logic [18:0] F3  = {3'b100, 4'b0100, 2'b10, 2'b00, 1'b0, 2'b01, 2'b00, 3'b000};
    localparam logic [18:0] F4  = {3'b100, 4'b1000, 2'b10, 2'b00, 1'b0, 2'b01, 2'b00, 3'b000};
    localparam logic [18:0] DEC = {3'b000, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 3'b000};
    localparam logic [18:0] MAD = {3'b000, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 3'b000};
    localparam logic [18:0] LRD = {3'b101, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] LWR = {3'b000, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b101};
    localparam logic [18:0] SWR = {3'b011, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] REX = {3'b000, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b10, 3'b000};
    localparam logic [18:0] RWR = {3'b000, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b110};
    localparam logic [18:0] BEX = {3'b000, 4'b0000, 2'b01, 2'b01, 1'b1, 2'b00, 2'b01, 3'b000};
    localparam logic [18:0] JEX = {3'b000, 4'b0000, 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 3'b000};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] e [5];
        reset = 1'b1;
        op = 6'b111111;
        #1;
        checks++;
        if (outv !== F1) begin
            errors++;
            $display("FAIL reset_hold got %h exp %h", outv, F1);
        end
        step();
        step();
        checks++;
        if (outv !== F1) begin
            errors++;
            $display("FAIL reset_clocked got %h exp %h", outv, F1);
        end
        @(negedge clk);
        reset = 1'b0;
        e = '{F2, F3, F4, DEC, F1};
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (outv !== e[i]) begin
                errors++;
                $display("FAIL reset_seq cyc%0d got %h exp %h", i, outv, e[i]);
            end
        end
    endtask

    task automatic test_lb();
        logic [18:0] e [9];
        op = 6'b100000;
        e = '{F1, F2, F3, F4, DEC, MAD, LRD, LWR, F1};
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (outv !== e[i]) begin
                errors++;
                $display("FAIL lb cyc%0d got %h exp %h", i, outv, e[i]);
            end
            if (i < 8) step();
        end
    endtask

    task automatic test_beq();
        logic [18:0] e [7];
        op = 6'b000100;
        e = '{F1, F2, F3, F4, DEC, BEX, F1};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (outv !== e[i]) begin
                errors++;
                $display("FAIL beq cyc%0d got %h exp %h", i, outv, e[i]);
            end
            if (i < 6) step();
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] e [6];
        logic [18:0] s [8];
        op = 6'b000010;
        e = '{F1, F2, F3, F4, DEC, JEX};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (outv !== e[i]) begin
                errors++;
                $display("FAIL j cyc%0d got %h exp %h", i, outv, e[i]);
            end
            step();
        end
        op = 6'b101000;
        s = '{F1, F2, F3, F4, DEC, MAD, SWR, F1};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outv !== s[i]) begin
                errors++;
                $display("FAIL sb cyc%0d got %h exp %h", i, outv, s[i]);
            end
            if (i < 7) step();
        end
    endtask

    task automatic test_illegal();
        logic [18:0] e [6];
        op = 6'b111111;
        e = '{F1, F2, F3, F4, DEC, F1};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (outv !== e[i]) begin
                errors++;
                $display("FAIL illegal cyc%0d got %h exp %h", i, outv, e[i]);
            end
            if (i < 5) step();
        end
    endtask

    task automatic test_async_reset();
        logic [18:0] e [6];
        op = 6'b000000;
        repeat (5) step();
        checks++;
        if (outv !== REX) begin
            errors++;
            $display("FAIL rtypeex got %h exp %h", outv, REX);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outv !== F1) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", outv, F1);
        end
        #1 reset = 1'b0;
        e = '{F2, F3, F4, DEC, REX, RWR};
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (outv !== e[i]) begin
                errors++;
                $display("FAIL resume cyc%0d got %h exp %h", i, outv, e[i]);
            end
        end
        step();
        checks++;
        if (outv !== F1) begin
            errors++;
            $display("FAIL resume_end got %h exp %h", outv, F1);
        end
    endtask

    task automatic test_random_mix();
        logic [5:0] ops [6];
        int lat [6];
        int k, cyc;
        ops = '{6'b100000, 6'b101000, 6'b000000,
                6'b000100, 6'b000010, 6'b001000};
        lat = '{8, 7, 7, 6, 6, 7};
        for (int n = 0; n < 1000; n++) begin
            k = int'($urandom_range(5, 0));
            op = ops[k];
            cyc = 0;
            do begin
                checks++;
                if (!$onehot0(irwrite) || (memread && memwrite) || (pcwrite && branch)) begin
                    errors++;
                    $display("FAIL invariant op %b cyc%0d got %h", op, cyc, outv);
                end
                step();
                cyc++;
            end while (outv !== F1 && cyc < 20);
            checks++;
            if (cyc !== lat[k]) begin
                errors++;
                $display("FAIL latency op %b got %0d exp %0d", op, cyc, lat[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_async_reset();
        test_random_mix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
